// File: rtl/acrtc_fb_writer_if.sv
// Capture-FIFO read port plus frame-RAM write port of the ACRTC frame-buffer writer.
// master = writer side, slave = FIFO/memory side.
interface acrtc_fb_writer_if #(
    parameter int ADDR_W = 20
);
    logic [31:0]       fb_in_rd;
    logic              fb_in_empty;
    logic              fb_in_ren;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wd;
    logic              mem_ack;

    modport master (
        input  fb_in_rd, fb_in_empty, mem_ack,
        output fb_in_ren, mem_req, mem_addr, mem_wd
    );

    modport slave (
        output fb_in_rd, fb_in_empty, mem_ack,
        input  fb_in_ren, mem_req, mem_addr, mem_wd
    );
endinterface

// File: rtl/acrtc_fb_writer.sv
// Drains the ACRTC capture FIFO into frame RAM, one req/ack write per captured word, with stats.
// Optional build macro FBW_SKIP_DUP_EN: suppress writes that repeat the last acked address/data.
module acrtc_fb_writer #(
    parameter int ADDR_W      = 20,
    parameter int FIFO_RD_LAT = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    acrtc_fb_writer_if.master    bus,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic [15:0]          wr_count,
    output logic [15:0]          drop_count,
    output logic                 busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LAT  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;

    localparam logic [1:0] LAT_LAST = 2'(FIFO_RD_LAT - 1);
    localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_lat_cnt;
    logic [7:0]        r_to_cnt;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wd;
    logic [15:0]       r_wr_count;
    logic [15:0]       r_drop_count;

    logic              w_capture;
    logic              w_tag_ok;
    logic [ADDR_W-1:0] w_map_addr;
    logic              w_dup;
    logic              w_acked;

    assign w_capture  = (r_state == S_LAT) && (r_lat_cnt == LAT_LAST);
    assign w_tag_ok   = (bus.fb_in_rd[31:30] == 2'b00);
    assign w_map_addr = base_addr + ADDR_W'(bus.fb_in_rd[29:16]);
    assign w_acked    = (r_state == S_REQ) && bus.mem_ack;

`ifdef FBW_SKIP_DUP_EN
    logic              r_last_vld;
    logic [ADDR_W-1:0] r_last_addr;
    logic [15:0]       r_last_wd;

    // Only a completed (acked) write becomes the reference; timeouts leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_vld  <= 1'b0;
            r_last_addr <= '0;
            r_last_wd   <= '0;
        end else if (w_acked) begin
            r_last_vld  <= 1'b1;
            r_last_addr <= r_mem_addr;
            r_last_wd   <= r_mem_wd;
        end
    end

    assign w_dup = r_last_vld && (w_map_addr == r_last_addr) && (bus.fb_in_rd[15:0] == r_last_wd);
`else
    assign w_dup = 1'b0;
`endif

    // Popping only from IDLE keeps at most one word in flight.
    assign bus.fb_in_ren = (r_state == S_IDLE) & ~bus.fb_in_empty & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= '0;
            r_to_cnt     <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
            r_wr_count   <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.fb_in_empty) begin
                        r_state   <= S_LAT;
                        r_lat_cnt <= '0;
                    end
                end
                S_LAT: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (w_capture) begin
                        if (!w_tag_ok) begin
                            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
                            r_state <= S_IDLE;
                        end else if (w_dup) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_mem_addr <= w_map_addr;
                            r_mem_wd   <= bus.fb_in_rd[15:0];
                            r_mem_req  <= 1'b1;
                            r_to_cnt   <= '0;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Ack takes priority over the timeout limit in the same cycle.
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
                        r_state   <= S_IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_mem_req <= 1'b0;
                        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_wd   = r_mem_wd;
    assign wr_count     = r_wr_count;
    assign drop_count   = r_drop_count;
    assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_acrtc_fb_writer.sv
// Directed, table-driven bench for acrtc_fb_writer (FIFO_RD_LAT=1, ACK_TIMEOUT=4).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_acrtc_fb_writer;
    localparam int ADDR_W = 20;
    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       wr_count;
    logic [15:0]       drop_count;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    acrtc_fb_writer_if #(.ADDR_W(ADDR_W)) bus ();

    acrtc_fb_writer #(
        .ADDR_W      (ADDR_W),
        .FIFO_RD_LAT (1),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .base_addr  (base_addr),
        .wr_count   (wr_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       word;
        logic [ADDR_W-1:0] base;
        int                ack_on;    // req cycle (1-based) on which to ack; 0 = never
        int                exp_req;   // expected number of req-high cycles
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0]       exp_wd;
        int                exp_wr;
        int                exp_drop;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_word(input int idx, input vec_t v);
        int req_cycles;
        int first_req;
        // c0: head of FIFO not yet valid; pop must be issued
        bus.fb_in_rd    = JUNK;
        bus.fb_in_empty = 1'b0;
        base_addr       = v.base;
        @(negedge clk);
        chk($sformatf("v%0d ren_c0", idx), {31'd0, bus.fb_in_ren}, 32'd1);
        @(posedge clk); #1;
        bus.fb_in_empty = 1'b1;
        bus.fb_in_rd    = v.word;
        @(negedge clk);
        chk($sformatf("v%0d ren_req_busy_c1", idx), {29'd0, bus.fb_in_ren, bus.mem_req, busy}, 32'd1);
        @(posedge clk); #1;
        bus.fb_in_rd = JUNK;
        base_addr    = ~v.base;
        req_cycles   = 0;
        first_req    = -1;
        for (int cyc = 2; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                req_cycles++;
                if (first_req < 0) first_req = cyc;
                chk($sformatf("v%0d addr_c%0d", idx, cyc), 32'(bus.mem_addr), 32'(v.exp_addr));
                chk($sformatf("v%0d wd_c%0d", idx, cyc), 32'(bus.mem_wd), 32'(v.exp_wd));
                if (req_cycles == v.ack_on) bus.mem_ack = 1'b1;
            end else if (!busy) begin
                break;
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
        end
        chk($sformatf("v%0d req_cycles", idx), 32'(req_cycles), 32'(v.exp_req));
        if (v.exp_req > 0) chk($sformatf("v%0d first_req", idx), 32'(first_req), 32'd2);
        chk($sformatf("v%0d wr_count", idx), 32'(wr_count), 32'(v.exp_wr));
        chk($sformatf("v%0d drop_count", idx), 32'(drop_count), 32'(v.exp_drop));
        chk($sformatf("v%0d busy_end", idx), {31'd0, busy}, 32'd0);
        $display("vec %0d word=0x%08h base=0x%05h reqs=%0d wr=%0d drop=%0d", idx, v.word, v.base,
                 req_cycles, wr_count, drop_count);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int seen;
`ifdef FBW_SKIP_DUP_EN
        w = 0;
`else
        w = 1;
`endif
        vecs[0] = '{32'h0123_ABCD, 20'h10000, 1, 1, 20'h10123, 16'hABCD, 1, 0};
        vecs[1] = '{32'hC000_1111, 20'h00000, 1, 0, 20'h00000, 16'h0000, 1, 1};
        vecs[2] = '{32'h0005_0077, 20'h10000, 1, 1, 20'h10005, 16'h0077, 2, 1};
        vecs[3] = '{32'h0005_0077, 20'h10000, 1, w, 20'h10005, 16'h0077, 2 + w, 1};
        vecs[4] = '{32'h0007_0555, 20'h20000, 0, 4, 20'h20007, 16'h0555, 2 + w, 2};
        vecs[5] = '{32'h0007_0555, 20'h20000, 4, 4, 20'h20007, 16'h0555, 3 + w, 2};
        vecs[6] = '{32'h0002_1234, 20'hFFFFF, 2, 2, 20'h00001, 16'h1234, 4 + w, 2};
        vecs[7] = '{32'h4000_0000, 20'h00000, 1, 0, 20'h00000, 16'h0000, 4 + w, 3};
        vecs[8] = '{32'h3FFF_FFFF, 20'hF0000, 3, 3, 20'hF3FFF, 16'hFFFF, 5 + w, 3};

        // Reset held with a non-empty FIFO
        rst             = 1'b0;
        bus.fb_in_empty = 1'b0;
        bus.fb_in_rd    = JUNK;
        bus.mem_ack     = 1'b0;
        base_addr       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ren", {31'd0, bus.fb_in_ren}, 32'd0);
        chk("rst req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst counts", {wr_count, drop_count}, 32'd0);
        chk("rst addr_wd", {12'd0, bus.mem_addr}, 32'd0);
        $display("reset: ren=%0b req=%0b busy=%0b wr=%0d drop=%0d", bus.fb_in_ren, bus.mem_req, busy,
                 wr_count, drop_count);
        @(posedge clk); #1;
        bus.fb_in_empty = 1'b1;
        rst             = 1'b1;

        for (int i = 0; i < 9; i++) run_word(i, vecs[i]);

        // Ack with no request outstanding must not count
        bus.mem_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack wr_count", 32'(wr_count), 32'(5 + w));
        chk("stray_ack req", {31'd0, bus.mem_req}, 32'd0);
        $display("stray ack: wr=%0d req=%0b", wr_count, bus.mem_req);

        // Long idle with an empty FIFO
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.fb_in_ren || busy) seen++;
        end
        chk("idle100 activity", 32'(seen), 32'd0);
        $display("idle 100 cycles: active cycles=%0d", seen);

        // Reset asserted while a request is outstanding
        @(posedge clk); #1;
        base_addr       = '0;
        bus.fb_in_rd    = JUNK;
        bus.fb_in_empty = 1'b0;
        @(posedge clk); #1;
        bus.fb_in_empty = 1'b1;
        bus.fb_in_rd    = 32'h0001_1111;
        @(posedge clk); #1;
        bus.fb_in_rd = JUNK;
        @(negedge clk);
        chk("midreq req_before", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midreq req_async", {31'd0, bus.mem_req}, 32'd0);
        chk("midreq busy", {31'd0, busy}, 32'd0);
        chk("midreq counts", {wr_count, drop_count}, 32'd0);
        $display("reset mid-req: req=%0b busy=%0b wr=%0d drop=%0d", bus.mem_req, busy, wr_count,
                 drop_count);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst idle", {30'd0, bus.mem_req, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
